// File: rtl/icache_refill_ctrl_if.sv
// Interface for the icache refill controller. It carries the miss handshake, the memory burst port,
// the data RAM write port and the tag write port.
interface icache_refill_ctrl_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int LINE_WORDS  = 8,
    parameter int INDEX_WIDTH = 6
);
    localparam int WORD_BITS   = $clog2(LINE_WORDS);
    localparam int OFFSET_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_BITS;

    logic                             miss_valid;
    logic [ADDR_WIDTH-1:0]            miss_addr;
    logic                             miss_ready;
    logic                             flush;
    logic                             mem_req_valid;
    logic [ADDR_WIDTH-1:0]            mem_req_addr;
    logic                             mem_req_ready;
    logic                             mem_resp_valid;
    logic [DATA_WIDTH-1:0]            mem_resp_data;
    logic                             ram_we;
    logic [INDEX_WIDTH+WORD_BITS-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0]            ram_wdata;
    logic                             tag_we;
    logic [INDEX_WIDTH-1:0]           tag_index;
    logic [TAG_WIDTH-1:0]             tag_value;
    logic                             refill_done;
    logic                             refill_busy;

    // The controller side.
    modport slave (
        input  miss_valid, miss_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        output miss_ready, mem_req_valid, mem_req_addr, ram_we, ram_waddr, ram_wdata,
               tag_we, tag_index, tag_value, refill_done, refill_busy
    );

    // The environment side: the core, the memory and the cache arrays.
    modport master (
        output miss_valid, miss_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  miss_ready, mem_req_valid, mem_req_addr, ram_we, ram_waddr, ram_wdata,
               tag_we, tag_index, tag_value, refill_done, refill_busy
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill sequencer. It takes one miss, issues one line burst read, writes the
// returned beats into the data RAM and then writes the tag. A flush turns the refill into a silent drain.
module icache_refill_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int LINE_WORDS  = 8,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    icache_refill_ctrl_if.slave   bus
);
    localparam int WORD_BITS   = $clog2(LINE_WORDS);
    localparam int OFFSET_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_BITS;

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
    localparam logic [WORD_BITS-1:0]  LAST_BEAT   = WORD_BITS'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [WORD_BITS-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  aborted_q, aborted_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
            beat_cnt_q  <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        line_addr_d       = line_addr_q;
        beat_cnt_d        = beat_cnt_q;
        aborted_d         = aborted_q;
        bus.miss_ready    = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.ram_we        = 1'b0;
        bus.tag_we        = 1'b0;
        bus.refill_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.miss_ready = ~bus.flush;
                beat_cnt_d     = '0;
                if (bus.miss_valid && !bus.flush) begin
                    line_addr_d = bus.miss_addr & ~OFFSET_MASK;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // A flush here cannot withdraw the request; it only marks the burst for draining.
                bus.mem_req_valid = 1'b1;
                if (bus.flush) begin
                    aborted_d = 1'b1;
                end
                if (bus.mem_req_ready) begin
                    beat_cnt_d = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (bus.flush) begin
                    aborted_d = 1'b1;
                end
                if (bus.mem_resp_valid) begin
                    bus.ram_we = ~(aborted_q | bus.flush);
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        if (aborted_q || bus.flush) begin
                            aborted_d = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            state_d   = DONE;
                        end
                    end
                end
            end
            DONE: begin
                bus.tag_we      = ~bus.flush;
                bus.refill_done = ~bus.flush;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_req_addr = line_addr_q;
        bus.ram_waddr    = {line_addr_q[OFFSET_BITS +: INDEX_WIDTH], beat_cnt_q};
        bus.ram_wdata    = bus.mem_resp_data;
        bus.tag_index    = line_addr_q[OFFSET_BITS +: INDEX_WIDTH];
        bus.tag_value    = line_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
        bus.refill_busy  = (state_q != IDLE);
    end
endmodule
